// File: rtl/dca_lsu_txn_tracker.sv
// Transaction-info tracker for the DCA matrix LSU: a one-entry staging register resolves each
// descriptor's chain tag from its successor (or a flush), then a circular queue feeds downstream.
module dca_lsu_txn_tracker #(
  parameter int unsigned BW_ADDR = 32,
  parameter int unsigned BW_LEN  = 8,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned BW_TXN = BW_ADDR + BW_LEN + 2,
  localparam int unsigned BW_OCC = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              enable,
  input  logic              clear,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BW_TXN-1:0] in_info,
  output logic              out_valid,
  output logic [BW_TXN-1:0] out_info,
  input  logic              out_ready,
  output logic [BW_OCC-1:0] occupancy,
  output logic              idle
);

  localparam int unsigned BW_PTR = $clog2(DEPTH);
  localparam int unsigned BW_CNT = $clog2(DEPTH + 1);

  logic              r_staged_valid;
  logic [BW_TXN-1:0] r_staged_info;
  logic [BW_TXN-1:0] r_queue [DEPTH];
  logic [BW_PTR-1:0] r_wr_ptr;
  logic [BW_PTR-1:0] r_rd_ptr;
  logic [BW_CNT-1:0] r_count;

  logic              w_q_full;
  logic              w_q_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_standalone;
  logic              w_tag;
  logic [BW_TXN-1:0] w_push_entry;

  assign w_q_full     = (r_count == BW_CNT'(DEPTH));
  assign w_q_empty    = (r_count == '0);
  assign w_standalone = r_staged_info[BW_TXN-2];

  assign in_ready  = enable & (~r_staged_valid | ~w_q_full);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = enable & ~w_q_empty;
  assign out_info  = r_queue[r_rd_ptr];
  assign w_pop     = out_valid & out_ready;

  assign w_push = enable & r_staged_valid & ~w_q_full & (w_standalone | in_valid | flush);

  // The staged chain bit is dropped; the tag comes from whatever resolves this descriptor.
  always_comb begin
    w_tag = 1'b1;
    if (w_standalone) begin
      w_tag = 1'b0;
    end else if (in_valid) begin
      w_tag = in_info[BW_TXN-1];
    end
  end

  assign w_push_entry = {w_tag, r_staged_info[BW_TXN-2:0]};

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_staged_valid <= 1'b0;
      r_staged_info  <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else if (clear) begin
      r_staged_valid <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else begin
      if (w_accept) begin
        r_staged_info  <= in_info;
        r_staged_valid <= 1'b1;
      end else if (w_push) begin
        r_staged_valid <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_queue[r_wr_ptr] <= w_push_entry;
    end
  end

  assign occupancy = BW_OCC'(r_count) + BW_OCC'(r_staged_valid);
  assign idle      = (occupancy == '0);

endmodule

// File: tb/tb_dca_lsu_txn_tracker.sv
// Randomised and directed checks of dca_lsu_txn_tracker against a queue-based reference model.
module tb_dca_lsu_txn_tracker;

  localparam int unsigned BW_ADDR = 32;
  localparam int unsigned BW_LEN  = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned BW_TXN  = BW_ADDR + BW_LEN + 2;
  localparam int unsigned BW_OCC  = $clog2(DEPTH + 2);

  logic              clk = 1'b0;
  logic              rstnn;
  logic              enable, clear, flush, in_valid, out_ready;
  logic              in_ready, out_valid, idle;
  logic [BW_TXN-1:0] in_info, out_info;
  logic [BW_OCC-1:0] occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: staged descriptor plus an unbounded queue capped by DEPTH.
  bit                m_sv;
  logic [BW_TXN-1:0] m_si;
  logic [BW_TXN-1:0] m_q[$];

  dca_lsu_txn_tracker #(.BW_ADDR(BW_ADDR), .BW_LEN(BW_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstnn(rstnn), .enable(enable), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_info(in_info),
    .out_valid(out_valid), .out_info(out_info), .out_ready(out_ready),
    .occupancy(occupancy), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [BW_TXN-1:0] mk(input bit chain, input bit alone, input int unsigned len,
                                           input int unsigned addr);
    logic [BW_TXN-1:0] d;
    d = {chain, alone, BW_LEN'(len), BW_ADDR'(addr)};
    return d;
  endfunction

  task automatic drive(input bit en, input bit clr, input bit fl, input bit iv,
                       input logic [BW_TXN-1:0] inf, input bit ordy);
    enable = en; clear = clr; flush = fl; in_valid = iv; in_info = inf; out_ready = ordy;
  endtask

  // Checks outputs for the current inputs, advances the model, then crosses one clock edge.
  task automatic step();
    bit exp_ir, exp_ov, acc, pop, push, alone, tag;
    int sz;
    #2;
    sz     = m_q.size();
    exp_ir = enable && (!m_sv || sz < DEPTH);
    exp_ov = enable && sz > 0;
    check_eq("in_ready", 64'(in_ready), 64'(exp_ir));
    check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
    check_eq("occupancy", 64'(occupancy), 64'(sz + int'(m_sv)));
    check_eq("idle", 64'(idle), 64'((sz + int'(m_sv)) == 0));
    if (exp_ov) check_eq("out_info", 64'(out_info), 64'(m_q[0]));
    if (clear) begin
      m_sv = 0;
      m_q.delete();
    end else begin
      alone = m_si[BW_TXN-2];
      acc   = in_valid && exp_ir;
      pop   = exp_ov && out_ready;
      push  = enable && m_sv && sz < DEPTH && (alone || in_valid || flush);
      tag   = alone ? 1'b0 : (in_valid ? in_info[BW_TXN-1] : 1'b1);
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({tag, m_si[BW_TXN-2:0]});
      if (acc) begin
        m_sv = 1;
        m_si = in_info;
      end else if (push) begin
        m_sv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rstnn = 1'b0;
    #1;
    m_sv = 0;
    m_q.delete();
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rstnn = 1'b1;
  endtask

  initial begin
    rstnn = 1'b0;
    drive(0, 0, 0, 0, '0, 0);
    m_sv = 0;
    #3;
    check_eq("reset_in_ready", 64'(in_ready), 64'd0);
    check_eq("reset_idle", 64'(idle), 64'd1);
    @(posedge clk); #1;
    rstnn = 1'b1;

    // Three chained descriptors: first two leave with tags 0 and 1, third stays staged.
    drive(1, 0, 0, 1, mk(1, 0, 3, 'h100), 1); step();
    drive(1, 0, 0, 1, mk(0, 0, 4, 'h200), 1); step();
    drive(1, 0, 0, 1, mk(1, 0, 5, 'h300), 1); step();
    drive(1, 0, 0, 0, '0, 1); step();
    check_eq("t1_occupancy", 64'(occupancy), 64'd1);
    drive(1, 0, 1, 0, '0, 1); step();
    check_eq("t2_out_info", 64'(out_info), 64'(mk(1, 0, 5, 'h300)));
    drive(1, 0, 0, 0, '0, 1); step();
    check_eq("t2_idle", 64'(idle), 64'd1);

    // Standalone descriptor alone: 2-cycle latency, tag 0.
    drive(1, 0, 0, 1, mk(1, 1, 7, 'h400), 0); step();
    drive(1, 0, 0, 0, '0, 0); step();
    check_eq("t3_out_valid", 64'(out_valid), 64'd1);
    check_eq("t3_out_info", 64'(out_info), 64'(mk(0, 1, 7, 'h400)));
    drive(1, 0, 0, 0, '0, 1); step();

    // Fill: six offered with out_ready low, five accepted.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 1, mk(i[0], 0, i, 'h1000 + i), 0); step();
    end
    check_eq("t4_occupancy", 64'(occupancy), 64'd5);
    check_eq("t4_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, '0, 1); step();
    end
    drive(1, 0, 1, 0, '0, 1); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, '0, 1); step();
    end
    check_eq("t4_idle", 64'(idle), 64'd1);

    // Full queue with a staged standalone and a simultaneous pop: no push that cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, mk(1, 0, i, 'h2000 + i), 0); step();
    end
    drive(1, 0, 0, 1, mk(0, 1, 9, 'h2100), 0); step();
    check_eq("t5_full_occ", 64'(occupancy), 64'd5);
    drive(1, 0, 0, 0, '0, 1); step();
    check_eq("t5_no_push", 64'(occupancy), 64'd4);
    drive(1, 0, 0, 0, '0, 0); step();
    check_eq("t5_pushed", 64'(occupancy), 64'd4);
    check_eq("t5_staged_gone", 64'(in_ready), 64'd1);

    // Clear with enable low.
    drive(0, 1, 0, 0, '0, 0); step();
    check_eq("t6_clear_occ", 64'(occupancy), 64'd0);
    check_eq("t6_clear_idle", 64'(idle), 64'd1);

    // Rebuild some state, then reset asynchronously mid-transfer.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, mk(1, 0, i, 'h3000 + i), 0); step();
    end
    apply_reset();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 6),
            mk($urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom, $urandom),
            ((i / 40) % 3 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) < 7));
      step();
      if (i % 997 == 500) apply_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
